irq_ctrl: RTL and testbench

- Parametrised interrupt controller for the CPU I/O window; replaces the fixed OR of peripheral IRQs in the superio top.
- Collects N_SRC peripheral request lines and synchronises them. Latches them as level- or edge-triggered pending bits, applies per-source masks and a global enable.
- Drives one active-high irq; the top inverts it onto IRQ[0]. CPU reads a priority vector through the usual 8-bit AD/DI/DO/rw/cs register port, clocked by E.

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: 8-bit CPU register port (AD/DI/DO/rw/cs) for the interrupt controller.
interface irq_ctrl_if;
    logic [3:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    modport master (output AD, DI, rw, cs, input DO);
    modport slave  (input AD, DI, rw, cs, output DO);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller with level/edge pending latches,
// per-source masks, global enable, and a fixed-priority vector register.
// Optional macro IRQ_CTRL_NMI_EN adds an edge-latched nmi output for source NMI_SRC.
module irq_ctrl #(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NMI_SRC     = 0
) (
    input  logic             clk,
    input  logic             rst,
    irq_ctrl_if.slave        bus,
    input  logic [N_SRC-1:0] src,
    output logic             irq
`ifdef IRQ_CTRL_NMI_EN
    ,
    output logic             nmi
`endif
);

    typedef enum logic [3:0] {
        RAW_L   = 4'h0, RAW_H,  PEND_L,  PEND_H,
        MASK_L,         MASK_H, EDGE_L,  EDGE_H,
        VECTOR,         CTRL,   SWSET_L, SWSET_H,
        RSV_C,          RSV_D,  RSV_E,   RSV_F
    } reg_addr_t;

    if (N_SRC < 1 || N_SRC > 16) begin : g_bad_nsrc
        $error("irq_ctrl: N_SRC must be 1..16");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("irq_ctrl: SYNC_STAGES must be 0..3");
    end
    if (NMI_SRC >= N_SRC) begin : g_bad_nmi
        $error("irq_ctrl: NMI_SRC must be below N_SRC");
    end

    reg_addr_t        addr;
    logic             wr_en;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_sel;
    logic             gie;
    logic [N_SRC-1:0] lane;
    logic [N_SRC-1:0] wbits;
    logic [N_SRC-1:0] set;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] active;
    logic             any;
    logic [3:0]       vec_idx;
    logic             nmi_bit;
    logic [7:0]       rdata;

    assign addr  = reg_addr_t'(bus.AD);
    assign wr_en = bus.cs & ~bus.rw;

    // Synchroniser chain; s is src delayed by SYNC_STAGES clocks.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = src;
    end else begin : g_sync
        logic [N_SRC-1:0] stage [SYNC_STAGES];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            end else begin
                stage[0] <= src;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            end
        end
        assign s = stage[SYNC_STAGES-1];
    end

    // Map the 8-bit write byte onto source bits; AD[0] picks the low or high byte lane.
    always_comb begin
        lane  = '0;
        wbits = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            lane[i]  = (bus.AD[0] == (i >= 8));
            wbits[i] = lane[i] & bus.DI[3'(i % 8)];
        end
    end

    // Per-bit set/clear terms; set always dominates clear in the pending update.
    always_comb begin
        set = (s & ~edge_sel) | (s & ~prev & edge_sel);
        clr = '0;
        if (wr_en && addr inside {SWSET_L, SWSET_H}) set = set | wbits;
        if (wr_en && addr inside {PEND_L, PEND_H})   clr = wbits;
        if (wr_en && addr == CTRL && bus.DI[1])      clr = '1;
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        active  = pend & mask;
        any     = |active;
        vec_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (active[i-1]) vec_idx = 4'(i - 1);
        end
    end

    // Register state and the registered irq output.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            gie      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            prev <= s;
            pend <= (pend & ~clr) | set;
            if (wr_en && addr inside {MASK_L, MASK_H}) mask     <= (mask & ~lane) | wbits;
            if (wr_en && addr inside {EDGE_L, EDGE_H}) edge_sel <= (edge_sel & ~lane) | wbits;
            if (wr_en && addr == CTRL)                 gie      <= bus.DI[0];
            irq <= gie & (|(pend & mask));
        end
    end

`ifdef IRQ_CTRL_NMI_EN
    logic nmi_latch;

    // NMI latch: rising edge of NMI_SRC, independent of MASK/GIE/EDGE; set beats CTRL bit7 clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_latch <= 1'b0;
            nmi       <= 1'b0;
        end else begin
            nmi_latch <= (nmi_latch & ~(wr_en && addr == CTRL && bus.DI[7]))
                       | (s[NMI_SRC] & ~prev[NMI_SRC]);
            nmi       <= nmi_latch;
        end
    end

    assign nmi_bit = nmi_latch;
`else
    assign nmi_bit = 1'b0;
`endif

    function automatic logic [7:0] lane_of(input logic [N_SRC-1:0] v, input logic hi);
        logic [15:0] w;
        w            = '0;
        w[N_SRC-1:0] = v;
        return hi ? w[15:8] : w[7:0];
    endfunction

    // Combinational read mux; reads have no side effects.
    always_comb begin
        rdata = '0;
        case (addr)
            RAW_L,  RAW_H:  rdata = lane_of(s, bus.AD[0]);
            PEND_L, PEND_H: rdata = lane_of(pend, bus.AD[0]);
            MASK_L, MASK_H: rdata = lane_of(mask, bus.AD[0]);
            EDGE_L, EDGE_H: rdata = lane_of(edge_sel, bus.AD[0]);
            VECTOR:         rdata = any ? {4'b1000, vec_idx} : 8'h00;
            CTRL:           rdata = {nmi_bit, 6'b000000, gie};
            default:        rdata = '0;
        endcase
    end

    assign bus.DO = rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_irq_ctrl;
    localparam int NS = 16;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] src;
    logic        irq;
`ifdef IRQ_CTRL_NMI_EN
    logic        nmi;
`endif

    irq_ctrl_if bus();

    irq_ctrl #(.N_SRC(NS), .SYNC_STAGES(SS), .NMI_SRC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .src (src),
        .irq (irq)
`ifdef IRQ_CTRL_NMI_EN
        ,
        .nmi (nmi)
`endif
    );

    always #10 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Behavioural model: src history queue gives the delayed level, pending set as a bitmask.
    logic [15:0] hist[$];
    logic [15:0] m_prev, m_pend, m_mask, m_edge;
    logic        m_gie, m_irq, m_nl, m_nmi;

    function automatic logic [15:0] m_s();
        return (hist.size() >= SS) ? hist[SS-1] : 16'h0000;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [15:0] v;
        v = 16'h0000;
        case (a)
            4'd0, 4'd1: v = m_s();
            4'd2, 4'd3: v = m_pend;
            4'd4, 4'd5: v = m_mask;
            4'd6, 4'd7: v = m_edge;
            4'd8: begin
                for (int i = 0; i < NS; i++)
                    if ((m_pend[i] & m_mask[i]) == 1'b1) return 8'h80 | 8'(i);
                return 8'h00;
            end
            4'd9: return {m_nl, 6'b0, m_gie};
            default: return 8'h00;
        endcase
        return a[0] ? v[15:8] : v[7:0];
    endfunction

    task automatic tick();
        logic [15:0] s, d16, lane, set, clr;
        logic        w, n_irq;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '0;
            m_gie = 0; m_irq = 0; m_nl = 0; m_nmi = 0;
        end else begin
            s    = m_s();
            w    = bus.cs && !bus.rw;
            d16  = bus.AD[0] ? {bus.DI, 8'h00} : {8'h00, bus.DI};
            lane = bus.AD[0] ? 16'hFF00 : 16'h00FF;
            set  = '0;
            clr  = '0;
            for (int i = 0; i < NS; i++)
                set[i] = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
            if (w && (bus.AD == 4'd2 || bus.AD == 4'd3))   clr = d16;
            if (w && bus.AD == 4'd9 && bus.DI[1])          clr = 16'hFFFF;
            if (w && (bus.AD == 4'd10 || bus.AD == 4'd11)) set = set | d16;
            n_irq = m_gie && ((m_pend & m_mask) != 0);
`ifdef IRQ_CTRL_NMI_EN
            m_nmi = m_nl;
            m_nl  = (m_nl && !(w && bus.AD == 4'd9 && bus.DI[7])) || (s[0] && !m_prev[0]);
`endif
            m_pend = (m_pend & ~clr) | set;
            if (w && (bus.AD == 4'd4 || bus.AD == 4'd5)) m_mask = (m_mask & ~lane) | d16;
            if (w && (bus.AD == 4'd6 || bus.AD == 4'd7)) m_edge = (m_edge & ~lane) | d16;
            if (w && bus.AD == 4'd9) m_gie = bus.DI[0];
            m_irq  = n_irq;
            m_prev = s;
            hist.push_front(src);
            if (hist.size() > SS) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
        tick();
        bus.cs = 1'b0; bus.rw = 1'b1; bus.DI = 8'h00;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
        #1;
        d = bus.DO;
        bus.cs = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; src = 16'h00FF;
        ticks(2);
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            n_cmp++;
            if (d !== 8'h00) begin n_bad++; $display("FAIL reset_do[%0d]: got %h expected 00", a, d); end
        end
        rst = 1'b0;
        ticks(2);
        rd(4'd0, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL reset_raw_l: got %h expected ff", d); end
        tick();
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'hFF) begin n_bad++; $display("FAIL reset_pend_l: got %h expected ff", d); end
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq_masked: got %b expected 0", irq); end
        src = 16'h0000;
        ticks(3);
        wr(4'd9, 8'h02);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl_clear: got %h expected 00", d); end
    endtask

    task automatic test_level();
        logic [7:0] d;
        int lat;
        wr(4'd4, 8'h04);
        wr(4'd9, 8'h01);
        src = 16'h0004;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (irq === 1'b1 && lat == 0) lat = k;
            n_cmp++;
            if (irq !== m_irq) begin n_bad++; $display("FAIL level_irq_model: cyc %0d got %b expected %b", k, irq, m_irq); end
        end
        n_cmp++;
        if (lat != 4) begin n_bad++; $display("FAIL level_latency: got %0d expected 4", lat); end
        rd(4'd8, d);
        n_cmp++;
        if (d !== 8'h82) begin n_bad++; $display("FAIL level_vector: got %h expected 82", d); end
        wr(4'd2, 8'h04);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h04) begin n_bad++; $display("FAIL level_w1c_held: got %h expected 04", d); end
        src = 16'h0000;
        ticks(3);
        wr(4'd2, 8'h04);
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL level_irq_at_w1c: got %b expected 1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL level_irq_after_w1c: got %b expected 0", irq); end
    endtask

    task automatic test_edge_priority();
        logic [7:0] d;
        wr(4'd4, 8'h30);
        wr(4'd6, 8'h30);
        src = 16'h0020; tick();
        src = 16'h0000; tick();
        src = 16'h0010; tick();
        src = 16'h0000; ticks(4);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h30) begin n_bad++; $display("FAIL edge_pend: got %h expected 30", d); end
        rd(4'd8, d);
        n_cmp++;
        if (d !== 8'h84) begin n_bad++; $display("FAIL edge_vector4: got %h expected 84", d); end
        wr(4'd2, 8'h10);
        rd(4'd8, d);
        n_cmp++;
        if (d !== 8'h85) begin n_bad++; $display("FAIL edge_vector5: got %h expected 85", d); end
        wr(4'd2, 8'h20);
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL edge_irq_cleared: got %b expected 0", irq); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        wr(4'd6, 8'h32);
        src = 16'h0002;
        ticks(2);
        wr(4'd2, 8'h02);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h02) begin n_bad++; $display("FAIL simul_set_wins: got %h expected 02", d); end
        src = 16'h0000;
        ticks(3);
        wr(4'd2, 8'h02);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL simul_cleanup: got %h expected 00", d); end
    endtask

    task automatic test_swset_mode();
        logic [7:0] d;
        wr(4'd4, 8'h00);
        wr(4'd11, 8'h80);
        wr(4'd5, 8'h80);
        rd(4'd8, d);
        n_cmp++;
        if (d !== 8'h8F) begin n_bad++; $display("FAIL swset_vector: got %h expected 8f", d); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL swset_irq: got %b expected 1", irq); end
        wr(4'd3, 8'h80);
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL swset_clear_irq: got %b expected 0", irq); end
        src = 16'h0008;
        ticks(4);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h08) begin n_bad++; $display("FAIL mode_level_pend: got %h expected 08", d); end
        wr(4'd6, 8'h3A);
        wr(4'd2, 8'h08);
        ticks(3);
        rd(4'd2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL mode_no_spurious: got %h expected 00", d); end
        src = 16'h0000;
        ticks(3);
    endtask

`ifdef IRQ_CTRL_NMI_EN
    task automatic test_nmi();
        logic [7:0] d;
        int lat;
        wr(4'd4, 8'h00); wr(4'd5, 8'h00); wr(4'd6, 8'h00); wr(4'd9, 8'h00);
        src = 16'h0001; tick(); src = 16'h0000;
        lat = (nmi === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (nmi === 1'b1 && lat == 0) lat = k;
            n_cmp++;
            if (irq !== 1'b0) begin n_bad++; $display("FAIL nmi_irq_quiet: got %b expected 0", irq); end
        end
        n_cmp++;
        if (lat != 4) begin n_bad++; $display("FAIL nmi_latency: got %0d expected 4", lat); end
        rd(4'd9, d);
        n_cmp++;
        if (d !== 8'h80) begin n_bad++; $display("FAIL nmi_ctrl_read: got %h expected 80", d); end
        wr(4'd9, 8'h80);
        n_cmp++;
        if (nmi !== 1'b1) begin n_bad++; $display("FAIL nmi_at_clear: got %b expected 1", nmi); end
        tick();
        n_cmp++;
        if (nmi !== 1'b0) begin n_bad++; $display("FAIL nmi_after_clear: got %b expected 0", nmi); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] d;
        logic [3:0] a;
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) src = 16'($urandom);
            a = 4'($urandom_range(0, 15));
            bus.AD = a;
            bus.cs = ($urandom_range(0, 2) != 0);
            bus.rw = ($urandom_range(0, 2) != 0);
            bus.DI = 8'($urandom);
            if (a == 4'd9 && $urandom_range(0, 3) != 0) bus.DI[1] = 1'b0;
            #1;
            n_cmp++;
            if (bus.DO !== m_read(a)) begin
                n_bad++; $display("FAIL rand_do: cyc %0d AD %0d got %h expected %h", k, a, bus.DO, m_read(a));
            end
            tick();
            n_cmp++;
            if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq: cyc %0d got %b expected %b", k, irq, m_irq); end
`ifdef IRQ_CTRL_NMI_EN
            n_cmp++;
            if (nmi !== m_nmi) begin n_bad++; $display("FAIL rand_nmi: cyc %0d got %b expected %b", k, nmi, m_nmi); end
`endif
        end
        bus.cs = 1'b0; bus.rw = 1'b1; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = '0;
        bus.AD = '0; bus.DI = '0; bus.rw = 1'b1; bus.cs = 1'b0;
        m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '0;
        m_gie = 0; m_irq = 0; m_nl = 0; m_nmi = 0;
        #3;
        test_reset();
        test_level();
        test_edge_priority();
        test_simultaneous();
        test_swset_mode();
`ifdef IRQ_CTRL_NMI_EN
        test_nmi();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
